shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
Two-requester arbiter and sequencer for a single shared 32-bit barrel-shift resource in the five-stage pipeline.
- Requester 0 is the EX-stage ALU shift path; requester 1 is a secondary unit (e.g. a multicycle/CSR helper).
- Each request (operand, shift amount, ALU_mode) is accepted via valid/ready, shifted, and returned from a one-entry registered result slot tagged with the requester ID.
- Arbitration is round-robin when both requesters are valid.

Parameters:
- ID_W, 1, width of the response ID tag (fixed at 1 for two requesters).
- DATA_W, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 accepted this cycle
- req0_operand  in  32  requester 0 data
- req0_shamt  in  6  requester 0 shift amount, 0..63
- req0_mode  in  4  requester 0 ALU_mode code
- req1_valid / req1_ready / req1_operand / req1_shamt / req1_mode  same as requester 0, for requester 1
- resp_valid  out  1  result slot full
- resp_ready  in  1  consumer takes the result
- resp_result  out  32  shifted value
- resp_id  out  1  ID of the requester that produced the result
- busy  out  1  resp_valid OR any req valid

Behaviour:
- Reset (asynchronous, rst_n=0):
  - resp_valid=0, resp_result=0, resp_id=0.
  - last_grant=1, so requester 0 wins the first contested cycle.
  - Any in-flight result is discarded. The ready outputs are combinational and therefore 0 while resp_valid=0 is forced and no request is present.
- Slot free condition: slot_free = !resp_valid || resp_ready (pass-through on pop).
- Grant (combinational):
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = slot_free && grant==N. At most one ready is high per cycle.
  - A ready never depends on the ready of the other requester.
- Accept: on a clock edge with reqN_valid && reqN_ready:
  - resp_result <= shift(reqN_operand, reqN_shamt, reqN_mode)
  - resp_id <= N
  - resp_valid <= 1
  - last_grant <= N
  - Latency is exactly 1 cycle: accept at edge k, resp_valid visible after edge k.
- Pop without new accept: resp_valid <= 0. A simultaneous pop and accept keeps resp_valid=1 with new data, giving 1 result/cycle throughput.
- Backpressure: while resp_valid && !resp_ready, resp_result and resp_id stay stable and both readies are 0.
- Requesters must hold valid and payload stable until ready. The arbiter does not re-arbitrate away from a granted, still-valid requester in the same cycle.
- Shift function (pure arithmetic):
  - SLL: logical left shift.
  - SRL: logical right shift.
  - SRA: arithmetic right shift, sign = operand[31].
  - shamt >= 32: SLL/SRL give 0x00000000; SRA gives 32 copies of operand[31].
  - shamt = 0: operand unchanged.
  - Any other mode code: operand passed through unchanged.
- last_grant updates only on an accept; an idle cycle does not change it.

Optional Feature:
- Macro: SHIFT_ARB_STATS_EN.
- Defined: adds outputs stat_grant0 [15:0], stat_grant1 [15:0], stat_stall [15:0].
  - stat_grant0 / stat_grant1 increment on each accept from the respective requester.
  - stat_stall increments each cycle resp_valid && !resp_ready.
  - All three reset to 0 and wrap modulo 2^16.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared define header:
  - ALU_mode macros SLL, SRL, SRA (same codes the ALU uses).
  - Requester ID constants REQ_ALU=1'b0, REQ_AUX=1'b1.
- One sub-module: rr_arb2, the combinational two-way round-robin grant from (valid0, valid1, last_grant, slot_free).
- The shift function lives in shift_arbiter as a combinational block feeding the result register.

Test Plan:
- Single shift on req0: operand 0x00000001, shamt 4, SLL, resp_ready=1 → next cycle resp_valid=1, result 0x00000010, id 0.
- Single shift on req1: operand 0x80000000, shamt 4, SRA → result 0xF8000000, id 1. Same operand with SRL → 0x08000000.
- Boundary: shamt 32 SRL on 0xFFFFFFFF → 0x00000000. shamt 40 SRA on 0x80000000 → 0xFFFFFFFF. shamt 0 → operand. Unknown mode 4'hF → operand.
- Contention: both requesters valid for 4 cycles, resp_ready=1 → grants 0,1,0,1 on consecutive cycles, one result per cycle, ids matching.
- Backpressure: fill the slot, hold resp_ready=0 for 3 cycles with both valid → result/id stable, req0_ready=req1_ready=0. Release → pop and new accept in the same cycle.
- Reset mid-operation: assert rst_n=0 while resp_valid=1 → resp_valid=0 immediately (asynchronously). After release, contested request grants requester 0 first.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the shift arbiter: ALU_mode shift codes,
// requester ID tags and the request payload struct.
package shift_arbiter_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ID_W_DEF   = 1;
   localparam int SHAMT_W    = 6;
   localparam int MODE_W     = 4;
   localparam int STAT_W     = 16;

   // ALU_mode codes shared with the EX-stage ALU decoder
   localparam logic [MODE_W-1:0] ALU_SLL = 4'b0001;
   localparam logic [MODE_W-1:0] ALU_SRL = 4'b0101;
   localparam logic [MODE_W-1:0] ALU_SRA = 4'b1101;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] operand;
      logic [SHAMT_W-1:0]    shamt;
      logic [MODE_W-1:0]     mode;
   } shift_req_t;

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant. Contested cycles go to the
// requester that did not win the last accept.
module rr_arb2
   import shift_arbiter_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   input  logic slot_free,
   output logic grant_valid,
   output logic grant_id,
   output logic ready0,
   output logic ready1
);

   always_comb begin
      grant_valid = valid0 | valid1;
      grant_id    = REQ_ALU;
      if (valid0 && valid1) begin
         grant_id = ~last_grant;
      end else if (valid1) begin
         grant_id = REQ_AUX;
      end
   end

   // Each ready is derived from its own valid and the shared grant only.
   assign ready0 = slot_free && valid0 && (grant_id == REQ_ALU);
   assign ready1 = slot_free && valid1 && (grant_id == REQ_AUX);

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared 32-bit barrel shifter with a
// one-entry tagged result slot. Optional counters: SHIFT_ARB_STATS_EN.
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int ID_W   = ID_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [DATA_W-1:0]  req0_operand,
   input  logic [SHAMT_W-1:0] req0_shamt,
   input  logic [MODE_W-1:0]  req0_mode,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [DATA_W-1:0]  req1_operand,
   input  logic [SHAMT_W-1:0] req1_shamt,
   input  logic [MODE_W-1:0]  req1_mode,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [DATA_W-1:0]  resp_result,
   output logic [ID_W-1:0]    resp_id,
`ifdef SHIFT_ARB_STATS_EN
   output logic [STAT_W-1:0]  stat_grant0,
   output logic [STAT_W-1:0]  stat_grant1,
   output logic [STAT_W-1:0]  stat_stall,
`endif
   output logic               busy
);

   // Handshake: a request transfers on a rising edge where reqN_valid and
   // reqN_ready are both high; the result transfers where resp_valid and
   // resp_ready are both high. Requesters hold valid/payload until ready.
   logic               slot_free;
   logic               grant_valid;
   logic               grant_id;
   logic               last_grant;
   logic               accept;
   shift_req_t         sel;
   logic [DATA_W-1:0]  shift_res;
   logic [4:0]         sh;

   assign slot_free = !resp_valid || resp_ready;

   rr_arb2 u_arb (
      .valid0      (req0_valid),
      .valid1      (req1_valid),
      .last_grant  (last_grant),
      .slot_free   (slot_free),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .ready0      (req0_ready),
      .ready1      (req1_ready)
   );

   assign accept = grant_valid && slot_free;

   always_comb begin
      if (grant_id == REQ_AUX) begin
         sel = '{operand: req1_operand, shamt: req1_shamt, mode: req1_mode};
      end else begin
         sel = '{operand: req0_operand, shamt: req0_shamt, mode: req0_mode};
      end
   end

   // shamt[5] set means the whole word is shifted out.
   always_comb begin
      shift_res = sel.operand;
      sh        = sel.shamt[4:0];
      case (sel.mode)
         ALU_SLL: shift_res = sel.shamt[5] ? '0 : (sel.operand << sh);
         ALU_SRL: shift_res = sel.shamt[5] ? '0 : (sel.operand >> sh);
         ALU_SRA: shift_res = sel.shamt[5] ? {DATA_W{sel.operand[DATA_W-1]}}
                                           : DATA_W'($signed(sel.operand) >>> sh);
         default: shift_res = sel.operand;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_id     <= '0;
         last_grant  <= REQ_AUX;
      end else if (accept) begin
         resp_valid  <= 1'b1;
         resp_result <= shift_res;
         resp_id     <= ID_W'(grant_id);
         last_grant  <= grant_id;
      end else if (resp_ready) begin
         resp_valid  <= 1'b0;
      end
   end

   assign busy = resp_valid | req0_valid | req1_valid;

`ifdef SHIFT_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grant0 <= '0;
         stat_grant1 <= '0;
         stat_stall  <= '0;
      end else begin
         if (accept && grant_id == REQ_ALU) stat_grant0 <= stat_grant0 + 1'b1;
         if (accept && grant_id == REQ_AUX) stat_grant1 <= stat_grant1 + 1'b1;
         if (resp_valid && !resp_ready)    stat_stall  <= stat_stall + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: single shifts, boundaries, round-robin
// contention, backpressure and asynchronous reset mid-operation.
module tb_shift_arbiter;
   import shift_arbiter_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_operand, req1_operand;
   logic [5:0]  req0_shamt, req1_shamt;
   logic [3:0]  req0_mode, req1_mode;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_result;
   logic [0:0]  resp_id;
   logic        busy;
`ifdef SHIFT_ARB_STATS_EN
   logic [15:0] stat_grant0, stat_grant1, stat_stall;
`endif

   int errors = 0;
   int checks = 0;

   shift_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_operand (req0_operand),
      .req0_shamt   (req0_shamt),
      .req0_mode    (req0_mode),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_operand (req1_operand),
      .req1_shamt   (req1_shamt),
      .req1_mode    (req1_mode),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_result  (resp_result),
      .resp_id      (resp_id),
`ifdef SHIFT_ARB_STATS_EN
      .stat_grant0  (stat_grant0),
      .stat_grant1  (stat_grant1),
      .stat_stall   (stat_stall),
`endif
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; resp_ready = 1;
      req0_operand = '0; req0_shamt = '0; req0_mode = '0;
      req1_operand = '0; req1_shamt = '0; req1_mode = '0;
      step();
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid);
      end
      checks++;
      if (resp_result !== 32'h0 || resp_id !== 1'b0) begin
         errors++; $display("FAIL reset_data got=%h/%b exp=0/0", resp_result, resp_id);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_ready got=%b%b busy=%b exp=00 busy=0", req0_ready, req1_ready, busy);
      end
      #2 rst_n = 1'b1;
      step();
   endtask

   // One uncontested request; result checked after the accepting edge,
   // slot checked empty one cycle later.
   task automatic issue(input int n, input logic [31:0] op, input logic [5:0] sh,
                        input logic [3:0] md, input logic [31:0] exp_res, input string name);
      if (n == 0) begin
         req0_valid = 1; req0_operand = op; req0_shamt = sh; req0_mode = md;
      end else begin
         req1_valid = 1; req1_operand = op; req1_shamt = sh; req1_mode = md;
      end
      resp_ready = 1;
      #1;
      checks++;
      if ((n == 0 ? req0_ready : req1_ready) !== 1'b1) begin
         errors++; $display("FAIL %s_ready got=%b%b exp_req=%0d", name, req0_ready, req1_ready, n);
      end
      step();
      req0_valid = 0; req1_valid = 0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== exp_res || resp_id !== 1'(n)) begin
         errors++;
         $display("FAIL %s got v=%b res=%h id=%b exp v=1 res=%h id=%0d",
                  name, resp_valid, resp_result, resp_id, exp_res, n);
      end
      step();
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++; $display("FAIL %s_pop got=%b exp=0", name, resp_valid);
      end
   endtask

   task automatic test_single();
      issue(0, 32'h0000_0001, 6'd4,  ALU_SLL, 32'h0000_0010, "sll4");
      issue(1, 32'h8000_0000, 6'd4,  ALU_SRA, 32'hF800_0000, "sra4");
      issue(1, 32'h8000_0000, 6'd4,  ALU_SRL, 32'h0800_0000, "srl4");
      issue(0, 32'h8000_0001, 6'd31, ALU_SLL, 32'h8000_0000, "sll31");
   endtask

   task automatic test_boundary();
      issue(0, 32'hFFFF_FFFF, 6'd32, ALU_SRL, 32'h0000_0000, "srl32");
      issue(1, 32'h8000_0000, 6'd40, ALU_SRA, 32'hFFFF_FFFF, "sra40");
      issue(0, 32'h7FFF_FFFF, 6'd40, ALU_SRA, 32'h0000_0000, "sra40_pos");
      issue(0, 32'h1234_5678, 6'd0,  ALU_SLL, 32'h1234_5678, "sh0");
      issue(0, 32'hDEAD_BEEF, 6'd3,  4'hF,    32'hDEAD_BEEF, "mode_f0");
      issue(1, 32'hCAFE_F00D, 6'd8,  4'hF,    32'hCAFE_F00D, "mode_f1");
   endtask

   // Last accept was requester 1, so contested grants run 0,1,0,1.
   task automatic test_contention();
      logic [31:0] exp_q[$];
      logic        exp_id_q[$];
      logic [31:0] e;
      logic        eid;
      req0_valid = 1; req0_operand = 32'hAAAA_0000; req0_shamt = 6'd0; req0_mode = 4'h0;
      req1_valid = 1; req1_operand = 32'h0000_5555; req1_shamt = 6'd0; req1_mode = 4'h0;
      resp_ready = 1;
      for (int i = 0; i < 4; i++) begin
         eid = 1'(i % 2);
         exp_q.push_back(eid ? 32'h0000_5555 : 32'hAAAA_0000);
         exp_id_q.push_back(eid);
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         eid = exp_id_q[0];
         checks++;
         if (req0_ready !== ~eid || req1_ready !== eid) begin
            errors++; $display("FAIL rr_grant%0d got=%b%b exp_id=%b", i, req0_ready, req1_ready, eid);
         end
         step();
         e = exp_q.pop_front();
         eid = exp_id_q.pop_front();
         checks++;
         if (resp_valid !== 1'b1 || resp_result !== e || resp_id !== eid) begin
            errors++;
            $display("FAIL rr_result%0d got v=%b res=%h id=%b exp res=%h id=%b",
                     i, resp_valid, resp_result, resp_id, e, eid);
         end
      end
   endtask

   // Slot holds requester 1's result; stall 3 cycles then release.
   task automatic test_backpressure();
      resp_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp_valid !== 1'b1 ||
             resp_result !== 32'h0000_5555 || resp_id !== 1'b1) begin
            errors++;
            $display("FAIL stall%0d rdy=%b%b v=%b res=%h id=%b exp rdy=00 v=1 res=00005555 id=1",
                     i, req0_ready, req1_ready, resp_valid, resp_result, resp_id);
         end
         step();
      end
      resp_ready = 1;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL release_grant got=%b%b exp=10", req0_ready, req1_ready);
      end
      step();
      req0_valid = 0; req1_valid = 0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 32'hAAAA_0000 || resp_id !== 1'b0) begin
         errors++;
         $display("FAIL pop_accept got v=%b res=%h id=%b exp v=1 res=aaaa0000 id=0",
                  resp_valid, resp_result, resp_id);
      end
      step();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL drain got v=%b busy=%b exp 0 0", resp_valid, busy);
      end
   endtask

   task automatic test_reset_mid();
      // Leave last_grant at 0 with a stalled result in the slot.
      req0_valid = 1; req0_operand = 32'h0000_0003; req0_shamt = 6'd1; req0_mode = ALU_SLL;
      resp_ready = 0;
      step();
      req0_valid = 0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 32'h0000_0006) begin
         errors++; $display("FAIL mid_fill got v=%b res=%h exp v=1 res=00000006", resp_valid, resp_result);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || resp_result !== 32'h0 || resp_id !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got v=%b res=%h id=%b exp v=0 res=0 id=0", resp_valid, resp_result, resp_id);
      end
      step();
      #2 rst_n = 1'b1;
      req0_valid = 1; req0_operand = 32'h0000_0011; req0_shamt = 6'd0; req0_mode = 4'h0;
      req1_valid = 1; req1_operand = 32'h0000_0022; req1_shamt = 6'd0; req1_mode = 4'h0;
      resp_ready = 1;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL post_reset_grant got=%b%b exp=10", req0_ready, req1_ready);
      end
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 32'h0000_0011 || resp_id !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_result got v=%b res=%h id=%b exp v=1 res=00000011 id=0",
                  resp_valid, resp_result, resp_id);
      end
      req0_valid = 0; req1_valid = 0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundary();
      test_contention();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
